cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  leave IDLE, begin fetching
- instr  in  16  instruction word from instruction memory
- instr_valid  in  1  instr valid, instruction handshake
- mem_ack  in  1  data-memory access complete
- instr_req  out  1  instruction fetch request
- pc_inc  out  1  one-cycle program-counter increment pulse
- op_code  out  4  latched instr[15:12]
- rd_addr, rs1_addr, rs2_addr  out  4 each  latched instr[11:8], [7:4], [3:0]
- imm_out  out  16  sign-extended instr[7:0]
- imm_en  out  1  writeback selects immediate
- alu_en  out  1  ALU operation strobe
- mem_req  out  1  data-memory request
- mem_we  out  1  data-memory write (store)
- reg_we  out  1  register-file write pulse
- halted  out  1  HALT reached
- retired  out  16  retired-instruction count

Function
REQ-003 Opcodes SHALL decode as follows:
- 0000 NOP
- 0001 LOAD
- 0010 STORE
- 0011 LDI
- 0100-1110 ALU
- 1111 HALT
REQ-004 The FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-005 IDLE: the block SHALL wait for start=1, then go to FETCH on the next edge.
REQ-006 FETCH: instr_req=1 until instr_valid=1; on that edge the block SHALL latch instr into the IR and go to DECODE.
REQ-007 DECODE: the block SHALL last exactly one cycle, and op_code/addresses/imm_out SHALL be valid from this cycle until the next IR load.
REQ-008 DECODE next state SHALL be:
- HALT for 1111
- WB for NOP and LDI
- EXEC for ALU
- MEM for LOAD and STORE
REQ-009 EXEC: alu_en=1 for exactly one cycle, then WB.
REQ-010 MEM: mem_req=1 (mem_we=1 only for STORE) held until mem_ack=1, then WB; mem_req/mem_we SHALL drop in the cycle after ack.
REQ-011 WB: the block SHALL hold for one cycle with the following outputs, then go to FETCH:
- reg_we=1 for LOAD, LDI and ALU; reg_we=0 for NOP and STORE
- imm_en=1 only for LDI
- pc_inc=1
- retired incremented by 1
REQ-012 imm_en SHALL be 0 in every state except WB of LDI; with imm_en=0 and op_code=0001 the writeback mux selects rd_data_bus, and otherwise alu_out.
REQ-013 Instruction latency SHALL be FETCH(>=1) + DECODE(1) + EXEC/MEM(1 or >=1) + WB(1) cycles; LDI/NOP SHALL take 3 cycles with zero-wait fetch.
REQ-014 HALT: halted=1, and all request/strobe outputs SHALL be 0; the block SHALL stay in HALT until reset, and start SHALL be ignored.
REQ-015 retired SHALL wrap from 0xFFFF to 0x0000; a HALT instruction SHALL not count.
REQ-016 instr_valid outside FETCH and mem_ack outside MEM SHALL be ignored.
REQ-017 start asserted while not in IDLE SHALL have no effect.
REQ-018 imm_out SHALL be {{8{instr[7]}}, instr[7:0]}.
REQ-019 All outputs SHALL be registered or decoded from the state plus IR only, with no combinational path from any input to any output.

Reset
REQ-020 rst_n=0 SHALL force the following immediately, regardless of clk:
- state IDLE
- IR=0, so op_code and all addresses=0 and imm_out=0
- retired=0
- all strobes/requests and halted = 0
REQ-021 Reset asserted mid-FETCH or mid-MEM SHALL drop instr_req/mem_req at once; no reg_we or pc_inc SHALL be issued for the aborted instruction.
REQ-022 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-023 LDI: instr=0x3A85, zero-wait fetch -> DECODE imm_out=0xFF85, rd_addr=0xA; WB reg_we=1, imm_en=1, pc_inc=1; retired 0->1.
REQ-024 LOAD with mem_ack delayed 3 cycles: instr=0x1234 -> mem_req=1, mem_we=0 for 4 cycles; then WB reg_we=1, imm_en=0, op_code=0001.
REQ-025 STORE 0x2120 -> mem_req=1, mem_we=1 until ack; WB reg_we=0, pc_inc=1.
REQ-026 ALU 0x5321 -> alu_en pulses 1 cycle in EXEC, then WB reg_we=1; spurious mem_ack/instr_valid in EXEC are ignored.
REQ-027 HALT 0xF000 -> halted=1 permanently, retired unchanged, instr_req=0; start pulses are ignored; rst_n low -> IDLE, halted=0.
REQ-028 Preload retired=0xFFFF by executing 65535 NOPs, then one NOP -> retired=0x0000; rst_n asserted during MEM wait -> mem_req=0 same cycle, retired=0.

Source files
------------

// File: rtl/cpu_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control
// for a 16-bit instruction word, with a retired-instruction counter.
module cpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ack,
  output logic        instr_req,
  output logic        pc_inc,
  output logic [3:0]  op_code,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rs1_addr,
  output logic [3:0]  rs2_addr,
  output logic [15:0] imm_out,
  output logic        imm_en,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        halted,
  output logic [15:0] retired
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LDI   = 4'h3;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t             state, state_next;
  logic [INSTR_W-1:0] ir;

  logic instr_req_d, pc_inc_d, imm_en_d, alu_en_d;
  logic mem_req_d, mem_we_d, reg_we_d, halted_d;
  logic is_alu;

  // Instruction fields come straight from the IR, so they hold until the next fetch.
  assign op_code  = ir[15:12];
  assign rd_addr  = ir[11:8];
  assign rs1_addr = ir[7:4];
  assign rs2_addr = ir[3:0];
  assign imm_out  = {{8{ir[7]}}, ir[7:0]};
  assign is_alu   = (op_code >= 4'h4) && (op_code <= 4'hE);

  // State register and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && instr_valid) ir <= instr;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (instr_valid) state_next = S_DECODE;
      S_DECODE: begin
        if (op_code == OP_HALT)                           state_next = S_HALT;
        else if (op_code == OP_NOP || op_code == OP_LDI)  state_next = S_WB;
        else if (op_code == OP_LOAD || op_code == OP_STORE) state_next = S_MEM;
        else                                              state_next = S_EXEC;
      end
      S_EXEC:   state_next = S_WB;
      S_MEM:    if (mem_ack) state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state; the IR is stable across every
  // transition that matters here (it only changes on FETCH->DECODE).
  always_comb begin
    instr_req_d = 1'b0;
    pc_inc_d    = 1'b0;
    imm_en_d    = 1'b0;
    alu_en_d    = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    reg_we_d    = 1'b0;
    halted_d    = 1'b0;
    case (state_next)
      S_FETCH: instr_req_d = 1'b1;
      S_EXEC:  alu_en_d    = 1'b1;
      S_MEM: begin
        mem_req_d = 1'b1;
        mem_we_d  = (op_code == OP_STORE);
      end
      S_WB: begin
        pc_inc_d = 1'b1;
        imm_en_d = (op_code == OP_LDI);
        reg_we_d = (op_code == OP_LOAD) || (op_code == OP_LDI) || is_alu;
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs and retired counter (counts on WB entry, wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_req <= 1'b0;
      pc_inc    <= 1'b0;
      imm_en    <= 1'b0;
      alu_en    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      reg_we    <= 1'b0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      instr_req <= instr_req_d;
      pc_inc    <= pc_inc_d;
      imm_en    <= imm_en_d;
      alu_en    <= alu_en_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      reg_we    <= reg_we_d;
      halted    <= halted_d;
      if (state_next == S_WB) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: instruction classes, wait states, halt, wrap and async reset.
module tb_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic        instr_valid;
  logic        mem_ack;
  logic        instr_req, pc_inc, imm_en, alu_en, mem_req, mem_we, reg_we, halted;
  logic [3:0]  op_code, rd_addr, rs1_addr, rs2_addr;
  logic [15:0] imm_out, retired;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .instr_valid(instr_valid), .mem_ack(mem_ack), .instr_req(instr_req),
    .pc_inc(pc_inc), .op_code(op_code), .rd_addr(rd_addr), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .imm_out(imm_out), .imm_en(imm_en), .alu_en(alu_en),
    .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .halted(halted),
    .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_mem;

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0;
    repeat (3) tick();
    chk("rst_instr_req", 32'(instr_req), 0);
    chk("rst_op_code",   32'(op_code),   0);
    chk("rst_imm_out",   32'(imm_out),   0);
    chk("rst_retired",   32'(retired),   0);
    chk("rst_halted",    32'(halted),    0);

    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_wait_instr_req", 32'(instr_req), 0);

    // LDI, zero-wait fetch
    start = 1'b1; tick();
    chk("ldi_fetch_req", 32'(instr_req), 1);
    start = 1'b0; instr = 16'h3A85; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    chk("ldi_dec_imm",  32'(imm_out),  'hFF85);
    chk("ldi_dec_rd",   32'(rd_addr),  'hA);
    chk("ldi_dec_rs1",  32'(rs1_addr), 'h8);
    chk("ldi_dec_rs2",  32'(rs2_addr), 'h5);
    chk("ldi_dec_req",  32'(instr_req), 0);
    chk("ldi_dec_imm_en", 32'(imm_en), 0);
    tick();
    chk("ldi_wb_reg_we", 32'(reg_we), 1);
    chk("ldi_wb_imm_en", 32'(imm_en), 1);
    chk("ldi_wb_pc_inc", 32'(pc_inc), 1);
    chk("ldi_wb_retired", 32'(retired), 1);
    tick();
    chk("ldi_next_fetch", 32'(instr_req), 1);
    chk("ldi_pc_inc_drop", 32'(pc_inc), 0);
    chk("ldi_imm_en_drop", 32'(imm_en), 0);

    // LOAD with one fetch wait and three mem wait cycles
    instr = 16'h1234; tick();
    chk("load_fetch_wait", 32'(instr_req), 1);
    instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    chk("load_dec_op", 32'(op_code), 1);
    tick();
    n_mem = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req && !mem_we && !imm_en) n_mem++;
      mem_ack = (i == 3);
      tick();
    end
    mem_ack = 1'b0;
    chk("load_mem_cycles", 32'(n_mem), 4);
    chk("load_wb_mem_req", 32'(mem_req), 0);
    chk("load_wb_reg_we",  32'(reg_we), 1);
    chk("load_wb_imm_en",  32'(imm_en), 0);
    chk("load_wb_op",      32'(op_code), 1);
    chk("load_wb_retired", 32'(retired), 2);
    tick();

    // STORE
    instr = 16'h2120; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    chk("store_mem_req", 32'(mem_req), 1);
    chk("store_mem_we",  32'(mem_we), 1);
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    chk("store_wb_mem_req", 32'(mem_req), 0);
    chk("store_wb_mem_we",  32'(mem_we), 0);
    chk("store_wb_reg_we",  32'(reg_we), 0);
    chk("store_wb_pc_inc",  32'(pc_inc), 1);
    chk("store_wb_retired", 32'(retired), 3);
    tick();

    // ALU with spurious handshakes during EXEC
    instr = 16'h5321; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    chk("alu_exec_en", 32'(alu_en), 1);
    mem_ack = 1'b1; instr_valid = 1'b1; instr = 16'hF000; tick();
    chk("alu_wb_en_drop", 32'(alu_en), 0);
    chk("alu_wb_reg_we",  32'(reg_we), 1);
    chk("alu_wb_mem_req", 32'(mem_req), 0);
    chk("alu_wb_op",      32'(op_code), 5);
    chk("alu_wb_retired", 32'(retired), 4);
    mem_ack = 1'b0; instr_valid = 1'b0; tick();

    // NOP, with a stray start
    instr = 16'h0000; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; start = 1'b1; tick();
    start = 1'b0;
    chk("nop_wb_reg_we",  32'(reg_we), 0);
    chk("nop_wb_pc_inc",  32'(pc_inc), 1);
    chk("nop_wb_retired", 32'(retired), 5);
    tick();

    // HALT
    instr = 16'hF000; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    chk("halt_halted",  32'(halted), 1);
    chk("halt_retired", 32'(retired), 5);
    chk("halt_req",     32'(instr_req), 0);
    start = 1'b1; tick(); tick();
    start = 1'b0; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    chk("halt_sticky",       32'(halted), 1);
    chk("halt_sticky_req",   32'(instr_req), 0);
    chk("halt_sticky_pc",    32'(pc_inc), 0);
    chk("halt_sticky_ret",   32'(retired), 5);

    // Asynchronous reset out of HALT
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halted",  32'(halted), 0);
    chk("arst_retired", 32'(retired), 0);
    chk("arst_op",      32'(op_code), 0);
    tick();
    rst_n = 1'b1;

    // Counter wrap from 0xFFFF
    force dut.retired = 16'hFFFF;
    tick();
    release dut.retired;
    tick();
    chk("wrap_preload", 32'(retired), 'hFFFF);
    start = 1'b1; tick();
    start = 1'b0; instr = 16'h0000; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    chk("wrap_retired", 32'(retired), 0);
    tick();

    // Reset during MEM wait
    instr = 16'h1234; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick();
    chk("mrst_mem_req_pre", 32'(mem_req), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_mem_req", 32'(mem_req), 0);
    chk("mrst_retired", 32'(retired), 0);
    mem_ack = 1'b1; tick(); tick();
    chk("mrst_reg_we", 32'(reg_we), 0);
    chk("mrst_pc_inc", 32'(pc_inc), 0);
    rst_n = 1'b1; mem_ack = 1'b0; tick();
    chk("mrst_idle_req", 32'(instr_req), 0);

    // Reset during FETCH
    start = 1'b1; tick();
    start = 1'b0;
    chk("frst_req_pre", 32'(instr_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("frst_req", 32'(instr_req), 0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
